// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response signal bundle for alu_op_sequencer.
interface alu_op_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_a;
  logic [3:0]    cmd_b;
  logic [1:0]    cmd_op;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [1:0]    alu_op;
  logic [3:0]    alu_c;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_c;
  logic [1:0]    rsp_op;
  logic          rsp_err;
  logic          busy;
  logic [CW-1:0] fifo_count;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_c, rsp_op, rsp_err,
           busy, fifo_count
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_c, rsp_op, rsp_err,
           busy, fifo_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives them one at a time onto the ALU and returns tagged results.
// Defining ALU_MISR_EN adds an 8-bit response signature register (sig, cleared by sig_clr).
module alu_op_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef ALU_MISR_EN
  input  logic       sig_clr,
  output logic [7:0] sig,
`endif
  alu_op_sequencer_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [SW-1:0] wait_q, wait_d;
  logic [3:0]    alu_a_q, alu_a_d;
  logic [3:0]    alu_b_q, alu_b_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic [3:0]    rsp_c_q, rsp_c_d;
  logic [1:0]    rsp_op_q, rsp_op_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_valid_q, rsp_valid_d;

  logic          cmd_ready_s;
  logic          push_s;
  logic          pop_s;
  logic          rsp_fire_s;
  logic          div0_s;
  cmd_t          head_s;

  // Readiness depends only on current occupancy, so a full FIFO never accepts even while popping.
  assign cmd_ready_s = (count_q != CW'(DEPTH));
  assign push_s      = bus.cmd_valid && cmd_ready_s;
  assign rsp_fire_s  = rsp_valid_q && bus.rsp_ready;
  assign head_s      = mem_q[rd_ptr_q];
  assign div0_s      = (head_s.op == OP_DIV) && (head_s.b == 4'h0);

  // Sequencer next state, FIFO bookkeeping and ALU/response register updates.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_c_d     = rsp_c_q;
    rsp_op_d    = rsp_op_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    pop_s       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count_q != CW'(0)) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wait_q != SW'(0)) begin
          wait_d = wait_q - SW'(1);
        end else begin
          rsp_c_d     = bus.alu_c;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_fire_s) begin
          if (count_q != CW'(0)) begin
            pop_s = 1'b1;
          end else begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A divide-by-zero never reaches the ALU; its error response is produced directly.
    if (pop_s) begin
      if (div0_s) begin
        rsp_c_d     = 4'hF;
        rsp_err_d   = 1'b1;
        rsp_op_d    = OP_DIV;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end else begin
        alu_a_d     = head_s.a;
        alu_b_d     = head_s.b;
        alu_op_d    = head_s.op;
        rsp_op_d    = head_s.op;
        rsp_valid_d = 1'b0;
        wait_d      = SW'(SETTLE - 1);
        state_d     = ST_WAIT;
      end
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset discards queued and in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_q      <= SW'(0);
      wr_ptr_q    <= AW'(0);
      rd_ptr_q    <= AW'(0);
      count_q     <= CW'(0);
      alu_a_q     <= 4'h0;
      alu_b_q     <= 4'h0;
      alu_op_q    <= 2'b00;
      rsp_c_q     <= 4'h0;
      rsp_op_q    <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_c_q     <= rsp_c_d;
      rsp_op_q    <= rsp_op_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Command storage, written on each accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= cmd_t'(10'h000);
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= cmd_t'({bus.cmd_a, bus.cmd_b, bus.cmd_op});
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

`ifdef ALU_MISR_EN
  logic [7:0] sig_q, sig_d;

  function automatic logic [7:0] misr_next(input logic [7:0] cur, input logic err,
                                           input logic [1:0] op, input logic [3:0] c);
    logic fb;
    fb = cur[7] ^ cur[5] ^ cur[4] ^ cur[3];
    return {cur[6:0], fb} ^ {1'b0, err, op, c};
  endfunction

  // Signature folds in each response as it is handed off; clear wins over update.
  always_comb begin
    sig_d = sig_q;
    if (sig_clr) begin
      sig_d = 8'h00;
    end else if (rsp_fire_s) begin
      sig_d = misr_next(sig_q, rsp_err_q, rsp_op_q, rsp_c_q);
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 8'h00;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`endif

  assign bus.cmd_ready  = cmd_ready_s;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (state_q != ST_IDLE) || (count_q != CW'(0));
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed table, corner sequences, random scoreboard.
module tb_alu_op_sequencer;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DEPTH(DEPTH)) bus ();

`ifdef ALU_MISR_EN
  logic       sig_clr = 1'b0;
  logic [7:0] sig;
`endif

  alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef ALU_MISR_EN
    .sig_clr (sig_clr),
    .sig     (sig),
`endif
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] c;
    logic [1:0] op;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] c;
    logic       err;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  rsp_t exp_q[$];

  // 4-bit ALU behaviour: plain integer arithmetic reduced modulo 16.
  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b) + 16;
      2'd2:    r = int'(a) * int'(b);
      default: r = (b == 4'd0) ? 15 : int'(a) / int'(b);
    endcase
    return 4'(r % 16);
  endfunction

  function automatic rsp_t ref_rsp(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    rsp_t r;
    if (op == 2'd3 && b == 4'd0) begin
      r.c = 4'hF; r.op = 2'd3; r.err = 1'b1;
    end else begin
      r.c = alu_fn(a, b, op); r.op = op; r.err = 1'b0;
    end
    return r;
  endfunction

  assign bus.alu_c = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input rsp_t e);
    check({tag, "_c"},   bus.rsp_c,   e.c);
    check({tag, "_op"},  bus.rsp_op,  e.op);
    check({tag, "_err"}, bus.rsp_err, e.err);
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 4'd0;
    bus.cmd_b     = 4'd0;
    bus.cmd_op    = 2'd0;
    bus.rsp_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One command into an idle block, checking ALU drive, latency and the response.
  task automatic send_one(input vec_t v);
    logic [3:0] pa, pb;
    logic [1:0] pop;
    bit         div0;
    int         k;
    rsp_t       e;
    div0 = (v.op == 2'd3) && (v.b == 4'd0);
    pa = bus.alu_a; pb = bus.alu_b; pop = bus.alu_op;
    bus.cmd_a = v.a; bus.cmd_b = v.b; bus.cmd_op = v.op;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 1;
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        check("alu_a",  bus.alu_a,  div0 ? 32'(pa)  : 32'(v.a));
        check("alu_b",  bus.alu_b,  div0 ? 32'(pb)  : 32'(v.b));
        check("alu_op", bus.alu_op, div0 ? 32'(pop) : 32'(v.op));
      end
    end
    check("latency", k, div0 ? 2 : 2 + SETTLE);
    e.c = v.c; e.op = v.op; e.err = v.err;
    check_rsp("single", e);
    @(negedge clk);
    check("rsp_done", bus.rsp_valid, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  task automatic reset_tests();
    int k;
    bus.cmd_a = 4'd9; bus.cmd_b = 4'd8; bus.cmd_op = 2'd0;
    bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_alu_a", bus.alu_a, 9);
    rst_n = 1'b0;
    #1;
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("held_rsp_valid", bus.rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rsp_drop", bus.rsp_valid, 0);
    check("rst_rsp_c", bus.rsp_c, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("post_rst_count", bus.fifo_count, 0);
    check("post_rst_busy", bus.busy, 0);
  endtask

  // Fill the FIFO under response backpressure, stall, then drain in order at full rate.
  task automatic backpressure();
    vec_t bp[6];
    int   acc, cyc, got, last;
    bp[0] = '{4'd1,  4'd2, 2'd0, 4'd0, 1'b0};
    bp[1] = '{4'd9,  4'd4, 2'd1, 4'd0, 1'b0};
    bp[2] = '{4'd7,  4'd3, 2'd2, 4'd0, 1'b0};
    bp[3] = '{4'd13, 4'd4, 2'd3, 4'd0, 1'b0};
    bp[4] = '{4'd6,  4'd6, 2'd0, 4'd0, 1'b0};
    bp[5] = '{4'd2,  4'd2, 2'd2, 4'd0, 1'b0};
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a = bp[acc].a; bus.cmd_b = bp[acc].b; bus.cmd_op = bp[acc].op;
      if (bus.cmd_ready) begin
        exp_q.push_back(ref_rsp(bp[acc].a, bp[acc].b, bp[acc].op));
        acc++;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_cmd_ready", bus.cmd_ready, 0);
    check("bp_count", bus.fifo_count, 4);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", bus.rsp_valid, 1);
      check_rsp("stall", exp_q[0]);
      check("stall_count", bus.fifo_count, 4);
    end
    bus.rsp_ready = 1'b1;
    cyc = 0; got = 0; last = -1;
    while (got < 5 && cyc < 50) begin
      if (bus.rsp_valid) begin
        check_rsp("bp_rsp", exp_q.pop_front());
        if (last >= 0) check("bp_gap", cyc - last, SETTLE + 1);
        last = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("bp_drained", got, 5);
    exp_q.delete();
  endtask

  task automatic scoreboard_cycle(input bit drive);
    logic [3:0] a, b;
    logic [1:0] op;
    if (drive) begin
      a  = 4'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
      op = 2'($urandom);
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", bus.rsp_valid, 0);
      end else begin
        check_rsp("rnd", exp_q[0]);
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      exp_q.push_back(ref_rsp(bus.cmd_a, bus.cmd_b, bus.cmd_op));
    end
    @(negedge clk);
  endtask

  task automatic random_phase(input int ncyc);
    int k;
    exp_q.delete();
    for (int i = 0; i < ncyc; i++) scoreboard_cycle(1'b1);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      scoreboard_cycle(1'b0);
      k++;
    end
    check("rnd_left", exp_q.size(), 0);
    check("rnd_busy", bus.busy, 0);
    check("rnd_count", bus.fifo_count, 0);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'd9,  4'd8,  2'd0, 4'd1,  1'b0};
    tbl[1] = '{4'd3,  4'd5,  2'd1, 4'd14, 1'b0};
    tbl[2] = '{4'd7,  4'd3,  2'd2, 4'd5,  1'b0};
    tbl[3] = '{4'd7,  4'd0,  2'd3, 4'd15, 1'b1};
    tbl[4] = '{4'd13, 4'd4,  2'd3, 4'd3,  1'b0};
    tbl[5] = '{4'd15, 4'd15, 2'd2, 4'd1,  1'b0};
    tbl[6] = '{4'd0,  4'd1,  2'd1, 4'd15, 1'b0};
    tbl[7] = '{4'd15, 4'd1,  2'd0, 4'd0,  1'b0};
    tbl[8] = '{4'd15, 4'd1,  2'd3, 4'd15, 1'b0};

    apply_reset();
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_count", bus.fifo_count, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_alu_a", bus.alu_a, 0);

    for (int i = 0; i < 9; i++) send_one(tbl[i]);

    reset_tests();
    apply_reset();
    backpressure();
    apply_reset();
    random_phase(400);

`ifdef ALU_MISR_EN
    apply_reset();
    check("sig_reset", sig, 8'h00);
    send_one('{4'd2, 4'd3, 2'd0, 4'd5, 1'b0});
    check("sig_add", sig, 8'h05);
    send_one('{4'd3, 4'd5, 2'd1, 4'd14, 1'b0});
    check("sig_sub", sig, 8'h14);
    sig_clr = 1'b1;
    @(negedge clk);
    sig_clr = 1'b0;
    check("sig_clr", sig, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
